// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage. Keeps a fetch pointer, issues requests to the
//   instruction memory and delivers one registered instruction per cycle to
//   the IF/ID register. Handles memory wait states, hazard freezes (a word
//   returning during a freeze is parked in a hold buffer) and branch
//   redirects (an in-flight request is allowed to finish and its data is
//   discarded).
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active low
//   Branch_taken    redirect request (priority over Freeze and returning data)
//   Branch_address  redirect target, sampled only with Branch_taken
//   Freeze          hazard stall: hold outputs, issue no new fetch
//   imem_req        memory request
//   imem_addr       memory fetch address (the fetch pointer)
//   imem_ready      memory completes the current request this cycle
//   imem_rdata      instruction word, valid with imem_ready
//   Instruction     registered instruction (0 = NOP on a bubble)
//   PC              registered fetch address + PC_STEP
//   Valid           Instruction/PC carry a real instruction
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_address,
    input  logic        Freeze,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic        Valid
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DROP  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcout_q, pcout_d;
    logic        valid_q, valid_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] pc_inc;

    // Modulo-2^32 increment: wrap-around is intentional.
    assign pc_inc = pc_q + PC_STEP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            pcout_q <= 32'd0;
            valid_q <= 1'b0;
            buf_q   <= 32'd0;
            redir_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcout_q <= pcout_d;
            valid_q <= valid_d;
            buf_q   <= buf_d;
            redir_q <= redir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcout_d = pcout_q;
        valid_d = valid_q;
        buf_d   = buf_q;
        redir_d = redir_q;

        case (state_q)
            S_FETCH: begin
                if (Branch_taken) begin
                    instr_d = 32'd0;
                    pcout_d = 32'd0;
                    valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d = Branch_address;
                    end else begin
                        // The pending request must complete at its original
                        // address; remember where to go once it does.
                        redir_d = Branch_address;
                        state_d = S_DROP;
                    end
                end else if (Freeze) begin
                    if (imem_ready) begin
                        buf_d   = imem_rdata;
                        pc_d    = pc_inc;
                        state_d = S_HOLD;
                    end
                end else if (imem_ready) begin
                    instr_d = imem_rdata;
                    pcout_d = pc_inc;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                end else begin
                    instr_d = 32'd0;
                    pcout_d = 32'd0;
                    valid_d = 1'b0;
                end
            end

            S_HOLD: begin
                if (Branch_taken) begin
                    instr_d = 32'd0;
                    pcout_d = 32'd0;
                    valid_d = 1'b0;
                    buf_d   = 32'd0;
                    pc_d    = Branch_address;
                    state_d = S_FETCH;
                end else if (!Freeze) begin
                    // pc_q already points past the buffered word.
                    instr_d = buf_q;
                    pcout_d = pc_q;
                    valid_d = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_DROP: begin
                instr_d = 32'd0;
                pcout_d = 32'd0;
                valid_d = 1'b0;
                if (Branch_taken) begin
                    redir_d = Branch_address;
                end
                if (imem_ready) begin
                    // The newest redirect wins, even one arriving this cycle.
                    pc_d    = Branch_taken ? Branch_address : redir_q;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Gating with rst keeps the request low throughout reset.
    assign imem_req    = rst & (state_q != S_HOLD);
    assign imem_addr   = pc_q;
    assign Instruction = instr_q;
    assign PC          = pcout_q;
    assign Valid       = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        Branch_taken;
    logic [31:0] Branch_address;
    logic        Freeze;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic        Valid;

    int errors = 0;
    int checks = 0;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .Branch_taken   (Branch_taken),
        .Branch_address (Branch_address),
        .Freeze         (Freeze),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .Instruction    (Instruction),
        .PC             (PC),
        .Valid          (Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        logic [31:0] ba;
        logic        frz;
        logic        rdy;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] i;
        logic [31:0] p;
    } out_t;

    vec_t vecs[$];
    out_t exp_q[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        return a | 32'hA000_0000;
    endfunction

    task automatic add(input logic br, input logic [31:0] ba, input logic frz,
                       input logic rdy, input logic ereq, input logic [31:0] eaddr,
                       input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.br = br; v.ba = ba; v.frz = frz; v.rdy = rdy;
        v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.ei = ei; v.ep = ep;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        out_t o;
        rst            = 1'b0;
        Branch_taken   = 1'b0;
        Branch_address = 32'd0;
        Freeze         = 1'b0;
        imem_ready     = 1'b0;
        imem_rdata     = 32'd0;

        // br ba frz rdy | req addr | V Instruction PC
        // zero-wait back-to-back
        add(0, 0, 0, 1,  1, 32'h0,   1, word(32'h0),   32'h4);
        add(0, 0, 0, 1,  1, 32'h4,   1, word(32'h4),   32'h8);
        // address 8 waits three cycles
        add(0, 0, 0, 0,  1, 32'h8,   0, 0, 0);
        add(0, 0, 0, 0,  1, 32'h8,   0, 0, 0);
        add(0, 0, 0, 0,  1, 32'h8,   0, 0, 0);
        add(0, 0, 0, 1,  1, 32'h8,   1, word(32'h8),   32'hC);
        // branch to 0x100 while the request to 12 waits two cycles
        add(1, 32'h100, 0, 0, 1, 32'hC, 0, 0, 0);
        add(0, 0, 0, 0,  1, 32'hC,   0, 0, 0);
        add(0, 0, 0, 1,  1, 32'hC,   0, 0, 0);
        add(0, 0, 0, 1,  1, 32'h100, 1, word(32'h100), 32'h104);
        // freeze for two cycles while ready (ready ignored during HOLD)
        add(0, 0, 1, 1,  1, 32'h104, 1, word(32'h100), 32'h104);
        add(0, 0, 1, 1,  0, 32'h108, 1, word(32'h100), 32'h104);
        add(0, 0, 0, 1,  0, 32'h108, 1, word(32'h104), 32'h108);
        add(0, 0, 0, 1,  1, 32'h108, 1, word(32'h108), 32'h10C);
        // freeze while the memory waits
        add(0, 0, 1, 0,  1, 32'h10C, 1, word(32'h108), 32'h10C);
        add(0, 0, 0, 1,  1, 32'h10C, 1, word(32'h10C), 32'h110);
        // branch + freeze + ready together, target exercises wrap-around
        add(1, 32'hFFFF_FFFC, 1, 1, 1, 32'h110, 0, 0, 0);
        add(0, 0, 0, 1,  1, 32'hFFFF_FFFC, 1, word(32'hFFFF_FFFC), 32'h0);
        add(0, 0, 0, 1,  1, 32'h0,   1, word(32'h0),   32'h4);
        // branch while in HOLD discards the buffer
        add(0, 0, 1, 1,  1, 32'h4,   1, word(32'h0),   32'h4);
        add(1, 32'h200, 1, 0, 0, 32'h8, 0, 0, 0);
        add(0, 0, 0, 1,  1, 32'h200, 1, word(32'h200), 32'h204);
        // second branch while dropping overwrites the redirect
        add(1, 32'h300, 0, 0, 1, 32'h204, 0, 0, 0);
        add(1, 32'h400, 0, 0, 1, 32'h204, 0, 0, 0);
        add(0, 0, 0, 1,  1, 32'h204, 0, 0, 0);
        add(0, 0, 0, 1,  1, 32'h400, 1, word(32'h400), 32'h404);
        // enter HOLD for the reset test below
        add(0, 0, 1, 1,  1, 32'h404, 1, word(32'h400), 32'h404);

        #12;
        chk("reset_valid", {31'd0, Valid}, 32'd0);
        chk("reset_instr", Instruction, 32'd0);
        chk("reset_pc", PC, 32'd0);
        chk("reset_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b1;
        #1;
        chk("post_reset_req", {31'd0, imem_req}, 32'd1);
        chk("post_reset_addr", imem_addr, 32'h0);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            Branch_taken   = vecs[k].br;
            Branch_address = vecs[k].ba;
            Freeze         = vecs[k].frz;
            imem_ready     = vecs[k].rdy;
            #1;
            chk($sformatf("v%0d_req", k), {31'd0, imem_req}, {31'd0, vecs[k].ereq});
            chk($sformatf("v%0d_addr", k), imem_addr, vecs[k].eaddr);
            imem_rdata = word(imem_addr);
            o.v = vecs[k].ev; o.i = vecs[k].ei; o.p = vecs[k].ep;
            exp_q.push_back(o);
            @(posedge clk);
            #1;
            o = exp_q.pop_front();
            chk($sformatf("v%0d_valid", k), {31'd0, Valid}, {31'd0, o.v});
            chk($sformatf("v%0d_instr", k), Instruction, o.i);
            chk($sformatf("v%0d_pc", k), PC, o.p);
        end

        // asynchronous reset pulse while in HOLD
        #2;
        Freeze     = 1'b1;
        imem_ready = 1'b0;
        rst        = 1'b0;
        #1;
        chk("hold_rst_valid", {31'd0, Valid}, 32'd0);
        chk("hold_rst_instr", Instruction, 32'd0);
        chk("hold_rst_pc", PC, 32'd0);
        chk("hold_rst_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rst          = 1'b1;
        Freeze       = 1'b0;
        Branch_taken = 1'b0;
        imem_ready   = 1'b1;
        #1;
        chk("hold_rst_req_rise", {31'd0, imem_req}, 32'd1);
        chk("hold_rst_addr", imem_addr, 32'h0);
        imem_rdata = word(imem_addr);
        @(posedge clk);
        #1;
        chk("hold_rst_first_valid", {31'd0, Valid}, 32'd1);
        chk("hold_rst_first_instr", Instruction, word(32'h0));
        chk("hold_rst_first_pc", PC, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter PC_STEP, default 32'd4, sequential PC increment.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 Branch_taken  input  1  redirect request from the branch/hazard logic.
REQ-006 Branch_address  input  32  redirect target; sampled only when Branch_taken=1.
REQ-007 Freeze  input  1  hazard stall; the unit holds its outputs and issues no new fetch.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  fetch address.
REQ-010 imem_ready  input  1  memory has completed the current request; imem_rdata is valid in this cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 Instruction  output  32  registered instruction feeding the IF/ID register Instruction_in.
REQ-013 PC  output  32  registered fetch address + PC_STEP, feeding IF/ID PC_in.
REQ-014 Valid  output  1  Instruction/PC hold a real instruction; 0 means bubble (Instruction=0, i.e. NOP).

Function
REQ-015 The unit SHALL keep an internal fetch pointer pc_reg and a 3-state FSM: FETCH, DROP, HOLD.
REQ-016 imem_req SHALL be 1 in FETCH and DROP and 0 in HOLD; imem_addr SHALL equal pc_reg.
REQ-017 Memory protocol: once raised, imem_req and imem_addr SHALL stay stable until a cycle with imem_ready=1; ready completes exactly one request; imem_ready while imem_req=0 SHALL be ignored.
REQ-018 FETCH, imem_ready=1, Branch_taken=0, Freeze=0: on the next edge, Instruction<=imem_rdata, PC<=pc_reg+PC_STEP, Valid<=1, pc_reg<=pc_reg+PC_STEP, stay in FETCH (back-to-back fetch, one instruction per cycle with zero-wait memory).
REQ-019 FETCH, imem_ready=0, Branch_taken=0, Freeze=0: Instruction<=0, PC<=0, Valid<=0 (bubble), and request remains pending.
REQ-020 FETCH, imem_ready=1, Freeze=1, Branch_taken=0: capture imem_rdata into a hold buffer, advance pc_reg by PC_STEP, go to HOLD; Instruction/PC/Valid unchanged.
REQ-021 FETCH, imem_ready=0, Freeze=1, Branch_taken=0: outputs unchanged, request remains pending.
REQ-022 HOLD, Freeze=1: outputs and buffer unchanged. HOLD, Freeze=0: present buffer (Instruction<=buffer, PC<=pc_reg, Valid<=1), go to FETCH.
REQ-023 Branch_taken=1 SHALL take priority over Freeze and over any returning data; outputs SHALL become a bubble (0/0/0) on the next edge.
REQ-024 Branch in FETCH with imem_ready=1, or in HOLD: discard data/buffer, pc_reg<=Branch_address, go to FETCH.
REQ-025 Branch in FETCH with imem_ready=0: latch Branch_address into redirect_pc, go to DROP (address not changed mid-request).
REQ-026 DROP: outputs are bubbles; on imem_ready=1 discard imem_rdata, pc_reg<=redirect_pc, go to FETCH; a new Branch_taken in DROP SHALL overwrite redirect_pc.
REQ-027 PC arithmetic SHALL be 32-bit modulo 2^32; pc_reg=32'hFFFF_FFFC with PC_STEP=4 wraps to 0 without error.
REQ-028 No instruction SHALL be delivered twice or skipped except those discarded by a redirect.

Reset
REQ-029 While rst=0, regardless of clk: state=FETCH, pc_reg=RESET_PC, Instruction=0, PC=0, Valid=0, buffer=0, redirect_pc=0.
REQ-030 imem_req SHALL be 0 while rst=0 and SHALL rise in the first cycle after rst deasserts, with imem_addr=RESET_PC.
REQ-031 Reset asserted mid-request or in HOLD/DROP SHALL abandon the transaction; the first post-reset fetch is to RESET_PC.

Verification
REQ-032 Zero-wait memory, imem_rdata=addr|32'hA000_0000 -> Valid=1 every cycle, PC sequence 4,8,12, Instruction A000_0000,A000_0004,...
REQ-033 imem_ready delayed 3 cycles on address 8 -> imem_addr held at 8 for 3 cycles, 3 bubbles out, then Instruction for address 8 with PC=12.
REQ-034 Freeze=1 for 2 cycles while ready=1 on address 4 -> outputs hold previous instruction, imem_req=0 for the frozen cycle after capture, address 4 word delivered with PC=8 on Freeze release, next fetch at 8.
REQ-035 Branch_taken=1, Branch_address=32'h100 while request to 12 waits 2 cycles -> imem_addr stays 12 until ready, word discarded, next imem_addr=32'h100, no Valid for address 12.
REQ-036 Branch_taken and Freeze and imem_ready all 1 in the same cycle -> bubble out, next imem_addr=Branch_address.
REQ-037 rst pulsed low in HOLD -> all outputs 0 immediately (asynchronous), first post-reset imem_addr=RESET_PC.
